m_br_predictor: RTL

//  Branch predictor feeding the IF-stage address mux of the 5-stage RV32I pipeline (m_proc14).

---
 rtl/m_br_predictor_if.sv | 23 ++
 rtl/m_br_predictor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/m_br_predictor_if.sv
// Fetch-lookup and EX-writeback signal bundle of the branch predictor.
// master = pipeline side, slave = predictor side.
interface m_br_predictor_if;
  logic [31:0] w_if_pc;
  logic        w_pred_hit;
  logic        w_pred_taken;
  logic [31:0] w_pred_tpc;
  logic        w_upd_v;
  logic [31:0] w_upd_pc;
  logic [31:0] w_upd_tpc;
  logic        w_upd_taken;
  logic        w_busy;

  modport master (
    output w_if_pc, w_upd_v, w_upd_pc, w_upd_tpc, w_upd_taken,
    input  w_pred_hit, w_pred_taken, w_pred_tpc, w_busy
  );

  modport slave (
    input  w_if_pc, w_upd_v, w_upd_pc, w_upd_tpc, w_upd_taken,
    output w_pred_hit, w_pred_taken, w_pred_tpc, w_busy
  );
endinterface

// File: rtl/m_br_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit saturating counters and a post-reset clear sweep.
// Optional BR_PRED_STATS_EN adds update / mispredict counters (w_n_br, w_n_miss).
module m_br_predictor #(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 12
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_ce,
  m_br_predictor_if.slave bp
`ifdef BR_PRED_STATS_EN
  ,
  output logic [31:0]     w_n_br,
  output logic [31:0]     w_n_miss
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    sat_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    sat_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  state_e              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic                valid_q [DEPTH];
  logic [TAG_W-1:0]    tag_q   [DEPTH];
  logic [ADDR_W-1:0]   tgt_q   [DEPTH];
  logic [1:0]          ctr_q   [DEPTH];

  logic [IDX_W-1:0]    lk_idx_s, up_idx_s, wr_idx_s;
  logic [TAG_W-1:0]    lk_tag_s, up_tag_s;
  logic                lk_hit_s, up_hit_s, upd_acc_s, wr_en_s;
  logic                valid_d;
  logic [TAG_W-1:0]    tag_d;
  logic [ADDR_W-1:0]   tgt_d;
  logic [1:0]          ctr_d;
  logic                unused_pc_s;

  assign lk_idx_s  = bp.w_if_pc[IDX_W+1:2];
  assign lk_tag_s  = bp.w_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx_s  = bp.w_upd_pc[IDX_W+1:2];
  assign up_tag_s  = bp.w_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit_s  = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
  assign up_hit_s  = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
  assign upd_acc_s = (state_q == S_RUN) && w_ce && bp.w_upd_v;
  assign bp.w_busy = (state_q == S_CLEAR);

  assign unused_pc_s = ^{bp.w_if_pc[31:IDX_W+TAG_W+2], bp.w_if_pc[1:0],
                         bp.w_upd_pc[31:IDX_W+TAG_W+2], bp.w_upd_pc[1:0],
                         bp.w_upd_tpc[31:ADDR_W+2], bp.w_upd_tpc[1:0]};

  // Lookup reads the table as it stands before this cycle's write, and is muted while clearing.
  always_comb begin
    bp.w_pred_hit   = 1'b0;
    bp.w_pred_taken = 1'b0;
    bp.w_pred_tpc   = 32'h0000_0000;
    if (!w_rst && (state_q == S_RUN) && lk_hit_s) begin
      bp.w_pred_hit   = 1'b1;
      bp.w_pred_taken = ctr_q[lk_idx_s][1];
      bp.w_pred_tpc   = {{(30-ADDR_W){1'b0}}, tgt_q[lk_idx_s], 2'b00};
    end else begin
      bp.w_pred_hit   = 1'b0;
    end
  end

  // Entry write selection: sweep invalidation or resolved-branch update.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    valid_d  = 1'b0;
    tag_d    = tag_q[up_idx_s];
    tgt_d    = tgt_q[up_idx_s];
    ctr_d    = ctr_q[up_idx_s];
    if (state_q == S_CLEAR) begin
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_q;
      valid_d  = 1'b0;
    end else if (upd_acc_s) begin
      wr_idx_s = up_idx_s;
      valid_d  = 1'b1;
      case ({up_hit_s, bp.w_upd_taken})
        2'b11: begin
          wr_en_s = 1'b1;
          ctr_d   = sat_inc(ctr_q[up_idx_s]);
          tgt_d   = bp.w_upd_tpc[ADDR_W+1:2];
        end
        2'b10: begin
          wr_en_s = 1'b1;
          ctr_d   = sat_dec(ctr_q[up_idx_s]);
        end
        2'b01: begin
          wr_en_s = 1'b1;
          tag_d   = up_tag_s;
          tgt_d   = bp.w_upd_tpc[ADDR_W+1:2];
          ctr_d   = 2'b10;
        end
        default: begin
          wr_en_s = 1'b0;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Clear/run FSM, sweep pointer and table storage; reset restarts the sweep from entry 0.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          ptr_q <= ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
          if (&ptr_q) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        default: begin
          state_q <= S_CLEAR;
          ptr_q   <= '0;
        end
      endcase
      if (wr_en_s) begin
        valid_q[wr_idx_s] <= valid_d;
        tag_q[wr_idx_s]   <= tag_d;
        tgt_q[wr_idx_s]   <= tgt_d;
        ctr_q[wr_idx_s]   <= ctr_d;
      end
    end
  end

`ifdef BR_PRED_STATS_EN
  logic [31:0] n_br_q, n_miss_q;
  logic        pred_old_s;

  // A table miss counts as a not-taken prediction.
  assign pred_old_s = up_hit_s && ctr_q[up_idx_s][1];

  // Saturating statistics of accepted updates and their mispredictions.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      n_br_q   <= 32'h0000_0000;
      n_miss_q <= 32'h0000_0000;
    end else if (upd_acc_s) begin
      if (n_br_q != 32'hFFFF_FFFF) begin
        n_br_q <= n_br_q + 32'h0000_0001;
      end
      if ((pred_old_s != bp.w_upd_taken) && (n_miss_q != 32'hFFFF_FFFF)) begin
        n_miss_q <= n_miss_q + 32'h0000_0001;
      end
    end else begin
      n_br_q   <= n_br_q;
      n_miss_q <= n_miss_q;
    end
  end

  assign w_n_br   = n_br_q;
  assign w_n_miss = n_miss_q;
`endif

endmodule
